montacargas_planta: RTL
=======================

Name: montacargas_planta

Overview:
- Behavioural plant model of the three-floor freight lift car, used on the test board and in simulation.
- Sits on the opposite side of the controller's motor/limit-switch interface: consumes the 2-bit MOTOR command and produces the FC1..FC3 limit-switch inputs.
- Models the car's position with spin-up delay and per-step travel time, and latches a fault on illegal commands or overtravel.

Parameters:
- FLOOR_STEPS, default 4: position steps between adjacent floors; top position TOP = 2*FLOOR_STEPS.
- STEP_DIV, default 2: clock cycles per position step while running (>=1).
- SPINUP_CYC, default 3: cycles a stable non-zero command must be held before motion starts (>=1).
- INIT_FLOOR, default 0: floor index 0..2 loaded at reset.

Ports:
- CLK  in  1  system clock; one clock domain only.
- RESET  in  1  asynchronous, active-low reset.
- MOTOR  in  2  car command: 2'b00 stop, 2'b10 up, 2'b01 down, 2'b11 illegal.
- FC1  out  1  car at floor 1 (pos == 0).
- FC2  out  1  car at floor 2 (pos == FLOOR_STEPS).
- FC3  out  1  car at floor 3 (pos == TOP).
- POS  out  clog2(TOP+1)  current car position.
- MOVING  out  1  high in RUN_UP or RUN_DN.
- FAULT  out  1  sticky fault flag.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (RESET=0, asynchronous) gives:
  - state STOP, pos = INIT_FLOOR*FLOOR_STEPS, spin-up and divider counters 0;
  - MOVING=0, FAULT=0;
  - FC outputs decoded from pos (for INIT_FLOOR=0: FC1=1, FC2=0, FC3=0).
- FC1..FC3 and POS are decoded from registered state with no extra latency. At most one FC is high at a time; none is high between floors.
- STOP:
  - MOTOR=00: stay.
  - MOTOR=10 or 01: go to SPINUP, latch the command as dir, spin-up counter = 1.
  - MOTOR=11: go to FLT.
- SPINUP:
  - MOTOR==dir: increment the counter. When the counter reaches SPINUP_CYC, go to RUN_UP or RUN_DN and clear the divider.
  - MOTOR changes to 00, or to the opposite direction: go to STOP. No motion. A reversal therefore always passes through STOP.
  - MOTOR=11: go to FLT.
- RUN_UP / RUN_DN:
  - The divider counts 0..STEP_DIV-1. At its terminal count pos moves by +1 (up) or -1 (down), and the divider wraps to 0.
  - First position change occurs STEP_DIV cycles after RUN entry.
  - MOTOR changes to anything else: go to STOP in the same edge; pos is held with no partial step; the divider is discarded.
  - MOTOR=11 always goes to FLT, with priority over any step.
- Overtravel: in RUN_UP with pos==TOP, or RUN_DN with pos==0, when a step falls due → go to FLT; pos stays at the end value.
- FLT:
  - FAULT=1, MOVING=0, pos frozen, all MOTOR values ignored.
  - Exit only by reset.
- Simultaneous events at the same edge: reset > illegal command > overtravel > command change > step.
- Arithmetic: pos is unsigned and never leaves 0..TOP. The spin-up and divider counters saturate and never wrap into a spurious step.
- Reset mid-motion: pos is forced back to the INIT_FLOOR value; motion history is not retained.

Decomposition:
- Shared package holds:
  - MOTOR encoding constants (MOT_STOP, MOT_UP, MOT_DN, MOT_ILL), shared with the controller;
  - the state enumeration (STOP, SPINUP, RUN_UP, RUN_DN, FLT).
- One natural sub-module: planta_divisor, a STEP_DIV tick generator with synchronous clear and enable, producing a one-cycle step pulse.
- FSM, position register and FC decode stay in the top.

Test Plan (FLOOR_STEPS=4, STEP_DIV=2, SPINUP_CYC=3, INIT_FLOOR=0):
- Reset and hold MOTOR=00 for 20 cycles → FC1=1, FC2=FC3=0, POS=0, MOVING=0, FAULT=0 throughout.
- MOTOR=10 held from edge E:
  - E+3: MOVING rises.
  - E+5: POS=1 and FC1 falls.
  - E+11: POS=4, FC2=1.
  - E+19: POS=8, FC3=1.
  - Release to 00 at E+19: STOP, POS stays 8.
- At POS=8, MOTOR=10 for 3+2 cycles → FAULT=1 at spin-up+2, POS=8. Then MOTOR=01 → no change until RESET=0, after which POS=0, FAULT=0.
- From POS=0:
  - MOTOR=10 for 6 cycles (POS=1), then 01 directly → STOP for 1 cycle, SPINUP, RUN_DN.
  - POS returns to 0 and FC1=1 at 1+3+2 cycles after the switch.
  - Holding 01 further → FAULT.
- MOTOR=11 for a single cycle during RUN_UP at POS=2 → FAULT=1 next edge, POS=2, MOVING=0.
- RESET asserted asynchronously mid-cycle during RUN_UP at POS=5 → POS=0, FC1=1, MOVING=0 immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/montacargas_planta_pkg.sv
// Shared definitions for the freight-lift car plant: motor command encoding
// (common with the controller) and the plant state enumeration.
package montacargas_planta_pkg;

   localparam logic [1:0] MOT_STOP = 2'b00;
   localparam logic [1:0] MOT_UP   = 2'b10;
   localparam logic [1:0] MOT_DN   = 2'b01;
   localparam logic [1:0] MOT_ILL  = 2'b11;

   typedef enum logic [2:0] {
      STOP   = 3'd0,
      SPINUP = 3'd1,
      RUN_UP = 3'd2,
      RUN_DN = 3'd3,
      FLT    = 3'd4
   } planta_state_t;

endpackage

// File: rtl/montacargas_planta_divisor.sv
// Step-rate tick generator: counts 0..STEP_DIV-1 while enabled and emits a
// one-cycle tick on the terminal count, then wraps. Clear has priority.
module planta_divisor #(
   parameter int STEP_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DW-1:0] TERM = DW'(STEP_DIV - 1);

   logic [DW-1:0] cnt;

   assign tick = en && !clr && (cnt == TERM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + DW'(1);
      end
   end

endmodule

// File: rtl/montacargas_planta.sv
// Behavioural plant of the three-floor freight lift car: turns MOTOR commands
// into car position and FC1..FC3 limit switches, with spin-up and sticky fault.
module montacargas_planta
   import montacargas_planta_pkg::*;
#(
   parameter int  FLOOR_STEPS = 4,
   parameter int  STEP_DIV    = 2,
   parameter int  SPINUP_CYC  = 3,
   parameter int  INIT_FLOOR  = 0,
   localparam int TOP         = 2 * FLOOR_STEPS,
   localparam int PW          = $clog2(TOP + 1)
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [1:0]    MOTOR,
   output logic          FC1,
   output logic          FC2,
   output logic          FC3,
   output logic [PW-1:0] POS,
   output logic          MOVING,
   output logic          FAULT,
   output logic [2:0]    dbg_state
);

   localparam int SW = $clog2(SPINUP_CYC + 1);
   localparam logic [PW-1:0] POS_TOP  = PW'(TOP);
   localparam logic [PW-1:0] POS_MID  = PW'(FLOOR_STEPS);
   localparam logic [PW-1:0] POS_INIT = PW'(INIT_FLOOR * FLOOR_STEPS);
   localparam logic [SW-1:0] SPIN_END = SW'(SPINUP_CYC);

   planta_state_t state, state_nx;
   logic [PW-1:0] pos, pos_nx;
   logic [SW-1:0] spin_cnt, spin_nx;
   logic [1:0]    dir, dir_nx;
   logic          running;
   logic          step_tick;

   assign running = (state == RUN_UP) || (state == RUN_DN);

   // Divider only advances while the held command still matches; any change
   // sends the FSM to STOP and the partial count is thrown away.
   planta_divisor #(
      .STEP_DIV (STEP_DIV)
   ) u_divisor (
      .clk   (CLK),
      .rst_n (RESET),
      .clr   (!running),
      .en    (running && (MOTOR == dir)),
      .tick  (step_tick)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= STOP;
         pos      <= POS_INIT;
         spin_cnt <= '0;
         dir      <= MOT_STOP;
      end else begin
         state    <= state_nx;
         pos      <= pos_nx;
         spin_cnt <= spin_nx;
         dir      <= dir_nx;
      end
   end

   // Priority inside each state: illegal command, overtravel, command change, step.
   always_comb begin
      state_nx = state;
      pos_nx   = pos;
      spin_nx  = spin_cnt;
      dir_nx   = dir;
      case (state)
         STOP: begin
            if (MOTOR == MOT_ILL) begin
               state_nx = FLT;
            end else if ((MOTOR == MOT_UP) || (MOTOR == MOT_DN)) begin
               state_nx = SPINUP;
               dir_nx   = MOTOR;
               spin_nx  = SW'(1);
            end
         end
         SPINUP: begin
            if (MOTOR == MOT_ILL) begin
               state_nx = FLT;
            end else if (MOTOR != dir) begin
               state_nx = STOP;
               spin_nx  = '0;
            end else if (spin_cnt >= SPIN_END) begin
               state_nx = (dir == MOT_UP) ? RUN_UP : RUN_DN;
            end else begin
               spin_nx = spin_cnt + SW'(1);
            end
         end
         RUN_UP: begin
            if (MOTOR == MOT_ILL) begin
               state_nx = FLT;
            end else if (MOTOR != MOT_UP) begin
               state_nx = STOP;
            end else if (step_tick) begin
               if (pos == POS_TOP) state_nx = FLT;
               else                pos_nx   = pos + PW'(1);
            end
         end
         RUN_DN: begin
            if (MOTOR == MOT_ILL) begin
               state_nx = FLT;
            end else if (MOTOR != MOT_DN) begin
               state_nx = STOP;
            end else if (step_tick) begin
               if (pos == '0) state_nx = FLT;
               else           pos_nx   = pos - PW'(1);
            end
         end
         FLT: begin
            state_nx = FLT;
         end
         default: begin
            state_nx = FLT;
         end
      endcase
   end

   assign FC1       = (pos == '0);
   assign FC2       = (pos == POS_MID);
   assign FC3       = (pos == POS_TOP);
   assign POS       = pos;
   assign MOVING    = running;
   assign FAULT     = (state == FLT);
   assign dbg_state = state;

endmodule
